// File: rtl/etapa_fetch_exe_if.sv
// Bundle of decode-side inputs and fetch/execute pipeline-register outputs of etapa_fetch_exe.
// The slave modport is the pipeline block; the master modport is the surrounding core.
interface etapa_fetch_exe_if #(
    parameter int PC_W    = 32,
    parameter int INSTR_W = 32,
    parameter int REG_W   = 4,
    parameter int CTRL_W  = 8,
    parameter int CNT_W   = 16
);
    logic               hazard;
    logic               flush;
    logic [PC_W-1:0]    branch_target;
    logic [INSTR_W-1:0] instr_in;
    logic [REG_W-1:0]   dec_Rd;
    logic               dec_mem_RE;
    logic               dec_RegW;
    logic [CTRL_W-1:0]  dec_ctrl;
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr_F;
    logic [PC_W-1:0]    pc_F;
    logic               valid_F;
    logic [REG_W-1:0]   Robj_Exe;
    logic               mem_RE_Exe;
    logic               RegW_Exe;
    logic [CTRL_W-1:0]  ctrl_Exe;
    logic [PC_W-1:0]    pc_Exe;
    logic               valid_Exe;
    logic [CNT_W-1:0]   stall_count;

    modport master (
        output hazard, flush, branch_target, instr_in,
        output dec_Rd, dec_mem_RE, dec_RegW, dec_ctrl,
        input  pc, instr_F, pc_F, valid_F,
        input  Robj_Exe, mem_RE_Exe, RegW_Exe, ctrl_Exe, pc_Exe, valid_Exe,
        input  stall_count
    );

    modport slave (
        input  hazard, flush, branch_target, instr_in,
        input  dec_Rd, dec_mem_RE, dec_RegW, dec_ctrl,
        output pc, instr_F, pc_F, valid_F,
        output Robj_Exe, mem_RE_Exe, RegW_Exe, ctrl_Exe, pc_Exe, valid_Exe,
        output stall_count
    );
endinterface

// File: rtl/etapa_fetch_exe.sv
// Program counter plus fetch/decode and decode/execute pipeline registers with
// load-use stall (hold + bubble), branch flush and a saturating stall counter.
module etapa_fetch_exe #(
    parameter int              PC_W     = 32,
    parameter int              INSTR_W  = 32,
    parameter int              REG_W    = 4,
    parameter int              CTRL_W   = 8,
    parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}},
    parameter int              CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    etapa_fetch_exe_if.slave    bus
);
    localparam logic [PC_W-1:0]  PC_STEP = PC_W'(32'd4);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(32'd1);

    logic [PC_W-1:0]    pc_r,        pc_nxt_s;
    logic [INSTR_W-1:0] instr_f_r,   instr_f_nxt_s;
    logic [PC_W-1:0]    pc_f_r,      pc_f_nxt_s;
    logic               valid_f_r,   valid_f_nxt_s;
    logic [REG_W-1:0]   rd_e_r,      rd_e_nxt_s;
    logic               mem_re_e_r,  mem_re_e_nxt_s;
    logic               regw_e_r,    regw_e_nxt_s;
    logic [CTRL_W-1:0]  ctrl_e_r,    ctrl_e_nxt_s;
    logic [PC_W-1:0]    pc_e_r,      pc_e_nxt_s;
    logic               valid_e_r,   valid_e_nxt_s;
    logic [CNT_W-1:0]   stall_cnt_r, stall_cnt_nxt_s;

    // Next-state selection: flush beats hazard beats advance; the execute register defaults to a bubble.
    always_comb begin
        pc_nxt_s        = pc_r;
        instr_f_nxt_s   = instr_f_r;
        pc_f_nxt_s      = pc_f_r;
        valid_f_nxt_s   = valid_f_r;
        stall_cnt_nxt_s = stall_cnt_r;
        rd_e_nxt_s      = {REG_W{1'b0}};
        mem_re_e_nxt_s  = 1'b0;
        regw_e_nxt_s    = 1'b0;
        ctrl_e_nxt_s    = {CTRL_W{1'b0}};
        pc_e_nxt_s      = {PC_W{1'b0}};
        valid_e_nxt_s   = 1'b0;
        if (bus.flush) begin
            pc_nxt_s      = bus.branch_target;
            instr_f_nxt_s = {INSTR_W{1'b0}};
            pc_f_nxt_s    = {PC_W{1'b0}};
            valid_f_nxt_s = 1'b0;
        end else if (bus.hazard) begin
            if (stall_cnt_r != CNT_MAX) begin
                stall_cnt_nxt_s = stall_cnt_r + CNT_ONE;
            end else begin
                stall_cnt_nxt_s = stall_cnt_r;
            end
        end else begin
            pc_nxt_s      = pc_r + PC_STEP;
            instr_f_nxt_s = bus.instr_in;
            pc_f_nxt_s    = pc_r;
            valid_f_nxt_s = 1'b1;
            // An empty fetch slot travels on as a bubble rather than stale decode fields.
            if (valid_f_r) begin
                rd_e_nxt_s     = bus.dec_Rd;
                mem_re_e_nxt_s = bus.dec_mem_RE;
                regw_e_nxt_s   = bus.dec_RegW;
                ctrl_e_nxt_s   = bus.dec_ctrl;
                pc_e_nxt_s     = pc_f_r;
                valid_e_nxt_s  = 1'b1;
            end else begin
                valid_e_nxt_s  = 1'b0;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r        <= RESET_PC;
            instr_f_r   <= {INSTR_W{1'b0}};
            pc_f_r      <= {PC_W{1'b0}};
            valid_f_r   <= 1'b0;
            rd_e_r      <= {REG_W{1'b0}};
            mem_re_e_r  <= 1'b0;
            regw_e_r    <= 1'b0;
            ctrl_e_r    <= {CTRL_W{1'b0}};
            pc_e_r      <= {PC_W{1'b0}};
            valid_e_r   <= 1'b0;
            stall_cnt_r <= {CNT_W{1'b0}};
        end else begin
            pc_r        <= pc_nxt_s;
            instr_f_r   <= instr_f_nxt_s;
            pc_f_r      <= pc_f_nxt_s;
            valid_f_r   <= valid_f_nxt_s;
            rd_e_r      <= rd_e_nxt_s;
            mem_re_e_r  <= mem_re_e_nxt_s;
            regw_e_r    <= regw_e_nxt_s;
            ctrl_e_r    <= ctrl_e_nxt_s;
            pc_e_r      <= pc_e_nxt_s;
            valid_e_r   <= valid_e_nxt_s;
            stall_cnt_r <= stall_cnt_nxt_s;
        end
    end

    assign bus.pc          = pc_r;
    assign bus.instr_F     = instr_f_r;
    assign bus.pc_F        = pc_f_r;
    assign bus.valid_F     = valid_f_r;
    assign bus.Robj_Exe    = rd_e_r;
    assign bus.mem_RE_Exe  = mem_re_e_r;
    assign bus.RegW_Exe    = regw_e_r;
    assign bus.ctrl_Exe    = ctrl_e_r;
    assign bus.pc_Exe      = pc_e_r;
    assign bus.valid_Exe   = valid_e_r;
    assign bus.stall_count = stall_cnt_r;
endmodule

// File: tb/tb_etapa_fetch_exe.sv
// Bench for etapa_fetch_exe: two instances (defaults; CNT_W=4 with RESET_PC near wrap) driven
// in lockstep, directed table + hand sequences + random stimulus against a pipeline model.
module tb_etapa_fetch_exe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    etapa_fetch_exe_if              i0 ();
    etapa_fetch_exe_if #(.CNT_W(4)) i1 ();

    etapa_fetch_exe dut0 (.clk(clk), .rst(rst), .bus(i0.slave));
    etapa_fetch_exe #(.CNT_W(4), .RESET_PC(32'hFFFF_FFF8)) dut1 (.clk(clk), .rst(rst), .bus(i1.slave));

    typedef struct {
        logic [31:0] pc;
        logic [31:0] f_instr;
        logic [31:0] f_pc;
        logic        f_v;
        logic [3:0]  e_rd;
        logic        e_mre;
        logic        e_rw;
        logic [7:0]  e_ctrl;
        logic [31:0] e_pc;
        logic        e_v;
        int          cnt;
    } mdl_t;

    typedef struct {
        bit          r, h, f;
        logic [31:0] bt;
        logic [31:0] pc;
        bit          vf, ve;
        int          cnt;
    } vec_t;

    mdl_t        m0, m1;
    vec_t        tbl[14];
    int          checks = 0;
    int          passes = 0;
    logic [3:0]  d_rd   = 4'd0;
    bit          d_mre  = 1'b0;
    bit          d_rw   = 1'b0;
    logic [7:0]  d_ctrl = 8'd0;

    function automatic logic [31:0] imem(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
    endfunction

    // One clock edge of the pipeline described as whole-register actions.
    function automatic mdl_t mstep(input mdl_t m, input bit r, h, f, input logic [31:0] bt,
                                   input int cmax, input logic [31:0] rpc);
        mdl_t n = m;
        mdl_t z = '{default: 0};
        if (r) begin
            n = z; n.pc = rpc;
        end else if (f) begin
            n = z; n.pc = bt; n.cnt = m.cnt;
        end else if (h) begin
            n = z;
            n.pc = m.pc; n.f_instr = m.f_instr; n.f_pc = m.f_pc; n.f_v = m.f_v;
            n.cnt = (m.cnt < cmax) ? m.cnt + 1 : cmax;
        end else begin
            n = z;
            n.cnt = m.cnt;
            n.pc = m.pc + 32'd4;
            n.f_instr = imem(m.pc); n.f_pc = m.pc; n.f_v = 1'b1;
            if (m.f_v) begin
                n.e_rd = d_rd; n.e_mre = d_mre; n.e_rw = d_rw; n.e_ctrl = d_ctrl;
                n.e_pc = m.f_pc; n.e_v = 1'b1;
            end
        end
        return n;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else passes++;
    endtask

    task automatic cmp(input string tag, input mdl_t a, input mdl_t e);
        check({tag, ".pc"},          64'(a.pc),      64'(e.pc));
        check({tag, ".instr_F"},     64'(a.f_instr), 64'(e.f_instr));
        check({tag, ".pc_F"},        64'(a.f_pc),    64'(e.f_pc));
        check({tag, ".valid_F"},     64'(a.f_v),     64'(e.f_v));
        check({tag, ".Robj_Exe"},    64'(a.e_rd),    64'(e.e_rd));
        check({tag, ".mem_RE_Exe"},  64'(a.e_mre),   64'(e.e_mre));
        check({tag, ".RegW_Exe"},    64'(a.e_rw),    64'(e.e_rw));
        check({tag, ".ctrl_Exe"},    64'(a.e_ctrl),  64'(e.e_ctrl));
        check({tag, ".pc_Exe"},      64'(a.e_pc),    64'(e.e_pc));
        check({tag, ".valid_Exe"},   64'(a.e_v),     64'(e.e_v));
        check({tag, ".stall_count"}, 64'(a.cnt),     64'(e.cnt));
    endtask

    function automatic mdl_t snap0();
        mdl_t s;
        s.pc = i0.pc; s.f_instr = i0.instr_F; s.f_pc = i0.pc_F; s.f_v = i0.valid_F;
        s.e_rd = i0.Robj_Exe; s.e_mre = i0.mem_RE_Exe; s.e_rw = i0.RegW_Exe;
        s.e_ctrl = i0.ctrl_Exe; s.e_pc = i0.pc_Exe; s.e_v = i0.valid_Exe;
        s.cnt = int'(i0.stall_count);
        return s;
    endfunction

    function automatic mdl_t snap1();
        mdl_t s;
        s.pc = i1.pc; s.f_instr = i1.instr_F; s.f_pc = i1.pc_F; s.f_v = i1.valid_F;
        s.e_rd = i1.Robj_Exe; s.e_mre = i1.mem_RE_Exe; s.e_rw = i1.RegW_Exe;
        s.e_ctrl = i1.ctrl_Exe; s.e_pc = i1.pc_Exe; s.e_v = i1.valid_Exe;
        s.cnt = int'(i1.stall_count);
        return s;
    endfunction

    // Drive both instances, take one edge, advance both models, compare everything #1 later.
    task automatic step(input bit r, h, f, input logic [31:0] bt);
        rst = r;
        i0.hazard = h; i1.hazard = h; i0.flush = f; i1.flush = f;
        i0.branch_target = bt; i1.branch_target = bt;
        i0.instr_in = imem(m0.pc); i1.instr_in = imem(m1.pc);
        i0.dec_Rd = d_rd; i1.dec_Rd = d_rd; i0.dec_mem_RE = d_mre; i1.dec_mem_RE = d_mre;
        i0.dec_RegW = d_rw; i1.dec_RegW = d_rw; i0.dec_ctrl = d_ctrl; i1.dec_ctrl = d_ctrl;
        @(posedge clk);
        m0 = mstep(m0, r, h, f, bt, 65535, 32'h0000_0000);
        m1 = mstep(m1, r, h, f, bt, 15, 32'hFFFF_FFF8);
        #1;
        cmp("d0", snap0(), m0);
        cmp("d1", snap1(), m1);
    endtask

    initial begin
        m0 = '{default: 0};
        m1 = '{default: 0};
        tbl[0]  = '{1'b1, 1'b1, 1'b1, 32'h200, 32'h000, 1'b0, 1'b0, 0};
        tbl[1]  = '{1'b1, 1'b1, 1'b1, 32'h200, 32'h000, 1'b0, 1'b0, 0};
        tbl[2]  = '{1'b1, 1'b1, 1'b1, 32'h200, 32'h000, 1'b0, 1'b0, 0};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 32'h000, 32'h004, 1'b1, 1'b0, 0};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 32'h000, 32'h008, 1'b1, 1'b1, 0};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 32'h000, 32'h008, 1'b1, 1'b0, 1};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 32'h000, 32'h00C, 1'b1, 1'b1, 1};
        tbl[7]  = '{1'b0, 1'b1, 1'b1, 32'h100, 32'h100, 1'b0, 1'b0, 1};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 32'h000, 32'h104, 1'b1, 1'b0, 1};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 32'h000, 32'h108, 1'b1, 1'b1, 1};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 32'h000, 32'h108, 1'b1, 1'b0, 2};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 32'h000, 32'h108, 1'b1, 1'b0, 3};
        tbl[12] = '{1'b1, 1'b1, 1'b0, 32'h000, 32'h000, 1'b0, 1'b0, 0};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 32'h000, 32'h004, 1'b1, 1'b0, 0};

        d_rd = 4'd3; d_mre = 1'b0; d_rw = 1'b1; d_ctrl = 8'h5A;
        for (int i = 0; i < 14; i++) begin
            step(tbl[i].r, tbl[i].h, tbl[i].f, tbl[i].bt);
            check($sformatf("tbl%0d.pc", i),      64'(i0.pc),          64'(tbl[i].pc));
            check($sformatf("tbl%0d.valid_F", i), 64'(i0.valid_F),     64'(tbl[i].vf));
            check($sformatf("tbl%0d.valid_E", i), 64'(i0.valid_Exe),   64'(tbl[i].ve));
            check($sformatf("tbl%0d.stall", i),   64'(i0.stall_count), 64'(tbl[i].cnt));
        end

        // Wrap on the high-reset instance.
        step(1'b1, 1'b0, 1'b0, 32'h0);
        check("wrap.pc0", 64'(i1.pc), 64'h0000_0000_FFFF_FFF8);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("wrap.pc1", 64'(i1.pc), 64'h0000_0000_FFFF_FFFC);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("wrap.pc2", 64'(i1.pc), 64'h0);

        // Load-use: load enters execute, one bubble, consumer follows.
        d_rd = 4'd5; d_mre = 1'b1; d_rw = 1'b1;
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("lu.load_rd",  64'(i0.Robj_Exe),   64'd5);
        check("lu.load_mre", 64'(i0.mem_RE_Exe), 64'd1);
        check("lu.instr_F",  64'(i0.instr_F),    64'(imem(32'd8)));
        d_rd = 4'd7; d_mre = 1'b0;
        step(1'b0, 1'b1, 1'b0, 32'h0);
        check("lu.hold_pc",  64'(i0.pc),         64'd12);
        check("lu.hold_F",   64'(i0.instr_F),    64'(imem(32'd8)));
        check("lu.bub_v",    64'(i0.valid_Exe),  64'd0);
        check("lu.bub_rd",   64'(i0.Robj_Exe),   64'd0);
        check("lu.bub_mre",  64'(i0.mem_RE_Exe), 64'd0);
        check("lu.stall",    64'(i0.stall_count), 64'd1);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("lu.cons_rd",  64'(i0.Robj_Exe),   64'd7);
        check("lu.cons_pc",  64'(i0.pc_Exe),     64'd8);
        check("lu.cons_v",   64'(i0.valid_Exe),  64'd1);

        // Reset mid-stall with a valid execute slot.
        step(1'b1, 1'b1, 1'b0, 32'h0);
        check("rms.pc0",  64'(i0.pc),        64'd0);
        check("rms.pc1",  64'(i1.pc),        64'h0000_0000_FFFF_FFF8);
        check("rms.vE",   64'(i0.valid_Exe), 64'd0);

        // Saturation of the 4-bit counter while the PC is frozen.
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b1, 1'b0, 32'h0);
            check($sformatf("sat%0d.pc", i), 64'(i1.pc), 64'h0000_0000_FFFF_FFF8);
        end
        check("sat.cnt4",  64'(i1.stall_count), 64'd15);
        check("sat.cnt16", 64'(i0.stall_count), 64'd20);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            d_rd = 4'($urandom); d_mre = 1'($urandom); d_rw = 1'($urandom);
            d_ctrl = 8'($urandom);
            step(($urandom_range(99) < 3), ($urandom_range(99) < 30),
                 ($urandom_range(99) < 10), $urandom & 32'hFFFF_FFFC);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
